// File: rtl/render_arbiter.sv
// Four-requester rectangle fill engine driving a VGA adapter.
// Round-robin arbitration, one pixel per cycle in raster order.
module render_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       req,
  input  logic [4*X_W-1:0] x_in,
  input  logic [4*Y_W-1:0] y_in,
  input  logic [4*X_W-1:0] w_in,
  input  logic [4*Y_W-1:0] h_in,
  input  logic [4*C_W-1:0] colour_in,
  output logic [3:0]       grant,
  output logic [3:0]       done,
  output logic             busy,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             plot
);

  localparam logic [X_W:0] SW_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH_L = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]     cur, last, win;
  logic           hit, first;
  logic [X_W-1:0] x_r, w_r, cx, hx, wsel;
  logic [Y_W-1:0] y_r, h_r, cy, hy, hsel;
  logic [C_W-1:0] col_r, hc;
  logic [X_W:0]   sx;
  logic [Y_W:0]   sy;
  logic           row_end, last_px;

  // Round-robin search starting one past the last winner
  always_comb begin
    win = last;
    hit = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(32'(last) + k)]) begin
        win = 2'(32'(last) + k);
        hit = 1'b1;
      end
    end
  end

  // Operand select for the winning requester
  always_comb begin
    wsel = w_in[32'(win)*X_W +: X_W];
    hsel = h_in[32'(win)*Y_W +: Y_W];
  end

  // Pixel position and raster bookkeeping
  always_comb begin
    sx      = {1'b0, x_r} + {1'b0, cx};
    sy      = {1'b0, y_r} + {1'b0, cy};
    row_end = (cx == w_r - 1'b1);
    last_px = row_end && (cy == h_r - 1'b1);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hit) state_nx = (wsel != '0 && hsel != '0) ? DRAW : DONE;
      DRAW: if (last_px) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, pixel counters and held VGA values
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur   <= '0;
      last  <= 2'd3;
      first <= 1'b0;
      x_r   <= '0;
      y_r   <= '0;
      w_r   <= '0;
      h_r   <= '0;
      col_r <= '0;
      cx    <= '0;
      cy    <= '0;
      hx    <= '0;
      hy    <= '0;
      hc    <= '0;
    end else begin
      first <= 1'b0;
      if (state == IDLE && hit) begin
        cur   <= win;
        last  <= win;
        first <= 1'b1;
        x_r   <= x_in[32'(win)*X_W +: X_W];
        y_r   <= y_in[32'(win)*Y_W +: Y_W];
        w_r   <= wsel;
        h_r   <= hsel;
        col_r <= colour_in[32'(win)*C_W +: C_W];
        cx    <= '0;
        cy    <= '0;
      end else if (state == DRAW) begin
        hx <= sx[X_W-1:0];
        hy <= sy[Y_W-1:0];
        hc <= col_r;
        if (row_end) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    busy       = (state != IDLE);
    grant      = first ? (4'd1 << cur) : 4'd0;
    done       = (state == DONE) ? (4'd1 << cur) : 4'd0;
    plot       = (state == DRAW) && (sx < SW_L) && (sy < SH_L);
    vga_x      = (state == DRAW) ? sx[X_W-1:0] : hx;
    vga_y      = (state == DRAW) ? sy[Y_W-1:0] : hy;
    vga_colour = (state == DRAW) ? col_r : hc;
  end

endmodule

// File: doc/render_arbiter.md
RENDER_ARBITER -- requirements
Module: render_arbiter

Interface
REQ-001 Parameter X_W, default 8, x-coordinate and rectangle-width width in bits.
REQ-002 Parameter Y_W, default 7, y-coordinate and rectangle-height width in bits.
REQ-003 Parameter C_W, default 3, colour width in bits.
REQ-004 Parameter SCREEN_W, default 160, visible columns; SCREEN_H, default 120, visible rows.
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port resetn  input  1  asynchronous, active-low reset.
REQ-007 Port req  input  4  per-requester draw request, bit i = requester i.
REQ-008 Port x_in  input  4*X_W  rectangle left edge, requester i at bits [i*X_W +: X_W].
REQ-009 Port y_in  input  4*Y_W  rectangle top edge, packed as x_in.
REQ-010 Port w_in  input  4*X_W  rectangle width in pixels, packed as x_in.
REQ-011 Port h_in  input  4*Y_W  rectangle height in pixels, packed as y_in.
REQ-012 Port colour_in  input  4*C_W  fill colour, packed as x_in.
REQ-013 Port grant  output  4  one-hot, one-cycle pulse: request i accepted, operands captured.
REQ-014 Port done  output  4  one-hot, one-cycle pulse: requester i rectangle complete.
REQ-015 Port busy  output  1  high in any state other than IDLE.
REQ-016 Port vga_x  output  X_W  pixel column to the VGA adapter.
REQ-017 Port vga_y  output  Y_W  pixel row to the VGA adapter.
REQ-018 Port vga_colour  output  C_W  pixel colour to the VGA adapter.
REQ-019 Port plot  output  1  pixel write enable to the VGA adapter.

Function
REQ-020 States: IDLE, DRAW, DONE; all outputs decoded from registered state, counters and captured operands.
REQ-021 IDLE: no req bit set -> stay IDLE; otherwise winner selected round-robin, starting the search at (last winner + 1) mod 4.
REQ-022 At the IDLE-exit edge, winner's x, y, w, h, colour captured; pixel counters cx, cy cleared.
REQ-023 IDLE -> DRAW when captured w and h are both nonzero; IDLE -> DONE when either is zero.
REQ-024 grant[winner] high for exactly the first cycle after the IDLE-exit edge (first DRAW cycle, or the DONE cycle for zero size).
REQ-025 DRAW: one pixel per cycle, raster order, cx inner (0..w-1), cy outer (0..h-1); DRAW lasts exactly w*h cycles.
REQ-026 vga_x = low X_W bits of (x + cx), vga_y = low Y_W bits of (y + cy), vga_colour = captured colour.
REQ-027 Sums computed at X_W+1 and Y_W+1 bits; plot high in a DRAW cycle only when x+cx < SCREEN_W and y+cy < SCREEN_H, otherwise plot low but the cycle still consumed.
REQ-028 Last pixel (cx = w-1, cy = h-1) -> DONE at the next edge.
REQ-029 DONE: exactly one cycle; done[winner] high, plot low; then -> IDLE.
REQ-030 Req deasserted before its grant: request withdrawn, no grant, no done.
REQ-031 Req bits and *_in changes after grant ignored until the next IDLE.
REQ-032 Req still high after its done: eligible again at lowest round-robin priority.
REQ-033 Minimum idle gap: one IDLE cycle between DONE and the next grant.
REQ-034 Outside DRAW, plot low; vga_x, vga_y, vga_colour hold their last values.

Reset
REQ-035 resetn low, at any time: state -> IDLE; grant, done, plot, busy -> 0; vga_x, vga_y, vga_colour, counters, captured operands -> 0; round-robin pointer set so requester 0 has highest priority.
REQ-036 Reset mid-DRAW or mid-DONE aborts the rectangle with no done pulse.
REQ-037 First arbitration at least one cycle after resetn rises.

Verification
REQ-038 After reset, req=0001, x=10, y=20, w=3, h=2, colour=5 -> grant[0] one cycle; 6 plot cycles (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 5; done[0] next cycle; busy low after.
REQ-039 req=1111 held continuously -> grants in order 0,1,2,3,0; each grant follows the previous done by two cycles.
REQ-040 Requester 2 w=0, h=5 -> grant[2] and done[2] both high in the same single cycle; no plot.
REQ-041 x=158, y=119, w=4, h=2 -> 8 DRAW cycles; plot high only at (158,119) and (159,119).
REQ-042 resetn pulsed low during the 3rd DRAW cycle -> plot, busy immediately 0; no done; next req=0011 granted to requester 0.
REQ-043 req[1] raised then dropped while requester 0 in DRAW -> requester 1 never granted.
